// File: rtl/wb_stage_pkg.sv
// rtl/wb_stage_pkg.sv - shared pipeline encodings and helpers for the writeback stage
package wb_stage_pkg;

    localparam logic [1:0] WB_SEL_ALU  = 2'b00;
    localparam logic [1:0] WB_SEL_MEM  = 2'b01;
    localparam logic [1:0] WB_SEL_LINK = 2'b10;
    localparam logic [1:0] WB_SEL_IMM  = 2'b11;

    localparam logic [1:0] MEM_SIZE_B = 2'b00;
    localparam logic [1:0] MEM_SIZE_H = 2'b01;
    localparam logic [1:0] MEM_SIZE_W = 2'b10;
    localparam logic [1:0] MEM_SIZE_D = 2'b11;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/wb_stage_load_extract.sv
// rtl/wb_stage_load_extract.sv - sub-word lane selection, extension and alignment check
module load_extract
    import wb_stage_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter bit BIG_ENDIAN = 1'b1,
    localparam int NB        = DATA_W / 8,
    localparam int OFF_W     = clog2(NB)
) (
    input  logic [DATA_W-1:0] data_i,
    input  logic [OFF_W-1:0]  off_i,
    input  logic [1:0]        size_i,
    input  logic              unsigned_i,
    output logic [DATA_W-1:0] value_o,
    output logic              misalign_o
);

    logic [7:0]        lane [NB];
    logic [DATA_W-1:0] raw;
    logic [OFF_W-1:0]  idx;
    logic              sign;
    int                nbytes;

    // lane[k] is the byte at memory address base+k
    for (genvar k = 0; k < NB; k++) begin : g_lane
        if (BIG_ENDIAN) begin : g_be
            assign lane[k] = data_i[DATA_W-1-8*k -: 8];
        end else begin : g_le
            assign lane[k] = data_i[8*k +: 8];
        end
    end

    always_comb begin
        case (size_i)
            MEM_SIZE_B: nbytes = 1;
            MEM_SIZE_H: nbytes = 2;
            MEM_SIZE_W: nbytes = 4;
            default:    nbytes = NB;
        endcase

        raw = '0;
        idx = '0;
        for (int i = 0; i < NB; i++) begin
            if (i < nbytes) begin
                idx = off_i + OFF_W'(i);
                if (BIG_ENDIAN) raw = {raw[DATA_W-9:0], lane[idx]};
                else            raw[8*i +: 8] = lane[idx];
            end
        end

        case (size_i)
            MEM_SIZE_B: sign = raw[7];
            MEM_SIZE_H: sign = raw[15];
            MEM_SIZE_W: sign = raw[31];
            default:    sign = raw[DATA_W-1];
        endcase
        sign = sign & ~unsigned_i;

        value_o = '0;
        for (int b = 0; b < DATA_W; b++) begin
            value_o[b] = (b < 8 * nbytes) ? raw[b] : sign;
        end
    end

    // A dword load cannot be satisfied by a 32-bit datapath at all.
    always_comb begin
        case (size_i)
            MEM_SIZE_B: misalign_o = 1'b0;
            MEM_SIZE_H: misalign_o = off_i[0];
            MEM_SIZE_W: misalign_o = (off_i[1:0] != 2'b00);
            default:    misalign_o = (NB == 8) ? (off_i != '0) : 1'b1;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - MEM/WB pipeline latch, writeback source mux and retired-instruction counter
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_AW     = 5,
    parameter int CNT_W      = 32,
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              valid_i,
    input  logic              reg_write_i,
    input  logic [1:0]        wb_sel_i,
    input  logic [1:0]        mem_size_i,
    input  logic              mem_unsigned_i,
    input  logic [REG_AW-1:0] rd_i,
    input  logic [DATA_W-1:0] alu_result_i,
    input  logic [DATA_W-1:0] read_data_i,
    input  logic [DATA_W-1:0] link_pc_i,
    input  logic [DATA_W-1:0] imm_i,
    output logic              rf_we_o,
    output logic [REG_AW-1:0] rf_waddr_o,
    output logic [DATA_W-1:0] rf_wdata_o,
    output logic              wb_valid_o,
    output logic              misalign_o,
    output logic [CNT_W-1:0]  instret_o
);

    localparam int OFF_W = clog2(DATA_W / 8);

    logic              valid_q, valid_d;
    logic              reg_write_q, reg_write_d;
    logic [1:0]        wb_sel_q, wb_sel_d;
    logic [1:0]        mem_size_q, mem_size_d;
    logic              mem_unsigned_q, mem_unsigned_d;
    logic [REG_AW-1:0] rd_q, rd_d;
    logic [DATA_W-1:0] alu_q, alu_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [DATA_W-1:0] link_q, link_d;
    logic [DATA_W-1:0] imm_q, imm_d;
    logic [CNT_W-1:0]  instret_q, instret_d;

    logic [DATA_W-1:0] load_value;
    logic              load_misalign;

    always_comb begin
        valid_d        = valid_q;
        reg_write_d    = reg_write_q;
        wb_sel_d       = wb_sel_q;
        mem_size_d     = mem_size_q;
        mem_unsigned_d = mem_unsigned_q;
        rd_d           = rd_q;
        alu_d          = alu_q;
        rdata_d        = rdata_q;
        link_d         = link_q;
        imm_d          = imm_q;
        // Flush only kills the control bits; data fields are left as-is.
        if (flush_i) begin
            valid_d     = 1'b0;
            reg_write_d = 1'b0;
        end else if (!stall_i) begin
            valid_d        = valid_i;
            reg_write_d    = reg_write_i;
            wb_sel_d       = wb_sel_i;
            mem_size_d     = mem_size_i;
            mem_unsigned_d = mem_unsigned_i;
            rd_d           = rd_i;
            alu_d          = alu_result_i;
            rdata_d        = read_data_i;
            link_d         = link_pc_i;
            imm_d          = imm_i;
        end
        instret_d = instret_q;
        if (valid_q && !stall_i && !flush_i) instret_d = instret_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q        <= 1'b0;
            reg_write_q    <= 1'b0;
            wb_sel_q       <= '0;
            mem_size_q     <= '0;
            mem_unsigned_q <= 1'b0;
            rd_q           <= '0;
            alu_q          <= '0;
            rdata_q        <= '0;
            link_q         <= '0;
            imm_q          <= '0;
            instret_q      <= '0;
        end else begin
            valid_q        <= valid_d;
            reg_write_q    <= reg_write_d;
            wb_sel_q       <= wb_sel_d;
            mem_size_q     <= mem_size_d;
            mem_unsigned_q <= mem_unsigned_d;
            rd_q           <= rd_d;
            alu_q          <= alu_d;
            rdata_q        <= rdata_d;
            link_q         <= link_d;
            imm_q          <= imm_d;
            instret_q      <= instret_d;
        end
    end

    load_extract #(
        .DATA_W    (DATA_W),
        .BIG_ENDIAN(BIG_ENDIAN)
    ) u_load_extract (
        .data_i    (rdata_q),
        .off_i     (alu_q[OFF_W-1:0]),
        .size_i    (mem_size_q),
        .unsigned_i(mem_unsigned_q),
        .value_o   (load_value),
        .misalign_o(load_misalign)
    );

    always_comb begin
        case (wb_sel_q)
            WB_SEL_ALU:  rf_wdata_o = alu_q;
            WB_SEL_MEM:  rf_wdata_o = load_value;
            WB_SEL_LINK: rf_wdata_o = link_q;
            default:     rf_wdata_o = imm_q;
        endcase
    end

    assign misalign_o = valid_q & (wb_sel_q == WB_SEL_MEM) & load_misalign;
    assign rf_we_o    = valid_q & reg_write_q & (rd_q != '0) & ~misalign_o;
    assign rf_waddr_o = rd_q;
    assign wb_valid_o = valid_q;
    assign instret_o  = instret_q;

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - directed table-driven bench for wb_stage
module tb_wb_stage;

    logic        clk;
    logic        rst_n;
    logic        stall_i, flush_i, valid_i, reg_write_i, mem_unsigned_i;
    logic [1:0]  wb_sel_i, mem_size_i;
    logic [4:0]  rd_i;
    logic [31:0] alu_result_i, read_data_i, link_pc_i, imm_i;
    logic        rf_we_o, wb_valid_o, misalign_o;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o, instret_o;

    int checks = 0;
    int errors = 0;
    int exp_instret = 0;
    logic mvalid = 1'b0;

    wb_stage #(.DATA_W(32), .REG_AW(5), .CNT_W(32), .BIG_ENDIAN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .flush_i(flush_i),
        .valid_i(valid_i), .reg_write_i(reg_write_i), .wb_sel_i(wb_sel_i),
        .mem_size_i(mem_size_i), .mem_unsigned_i(mem_unsigned_i), .rd_i(rd_i),
        .alu_result_i(alu_result_i), .read_data_i(read_data_i),
        .link_pc_i(link_pc_i), .imm_i(imm_i), .rf_we_o(rf_we_o),
        .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
        .wb_valid_o(wb_valid_o), .misalign_o(misalign_o), .instret_o(instret_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid, rw;
        logic [1:0]  sel, size;
        logic        uns;
        logic [4:0]  rd;
        logic [31:0] alu, rdata, link, imm;
        logic        e_we, e_mis, chk;
        logic [31:0] e_wdata;
    } vec_t;

    vec_t vecs[19];

    function automatic vec_t mk(logic valid, logic rw, logic [1:0] sel, logic [1:0] size,
                                logic uns, logic [4:0] rd, logic [31:0] alu, logic [31:0] rdata,
                                logic [31:0] link, logic [31:0] imm, logic e_we, logic e_mis,
                                logic chk, logic [31:0] e_wdata);
        vec_t v;
        v.valid = valid; v.rw = rw; v.sel = sel; v.size = size; v.uns = uns; v.rd = rd;
        v.alu = alu; v.rdata = rdata; v.link = link; v.imm = imm;
        v.e_we = e_we; v.e_mis = e_mis; v.chk = chk; v.e_wdata = e_wdata;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        valid_i = v.valid; reg_write_i = v.rw; wb_sel_i = v.sel; mem_size_i = v.size;
        mem_unsigned_i = v.uns; rd_i = v.rd; alu_result_i = v.alu; read_data_i = v.rdata;
        link_pc_i = v.link; imm_i = v.imm;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        vecs[0]  = mk(1, 1, 2'b00, 2'b10, 0, 5'd5,  32'h0000_1234, 32'h0,         32'h0, 32'h0, 1, 0, 1, 32'h0000_1234);
        vecs[1]  = mk(1, 1, 2'b01, 2'b00, 0, 5'd8,  32'h0000_1001, 32'h80FF_7F01, 32'h0, 32'h0, 1, 0, 1, 32'hFFFF_FFFF);
        vecs[2]  = mk(1, 1, 2'b01, 2'b00, 1, 5'd8,  32'h0000_1003, 32'h80FF_7F01, 32'h0, 32'h0, 1, 0, 1, 32'h0000_0001);
        vecs[3]  = mk(1, 1, 2'b01, 2'b00, 0, 5'd8,  32'h0000_1000, 32'h80FF_7F01, 32'h0, 32'h0, 1, 0, 1, 32'hFFFF_FF80);
        vecs[4]  = mk(1, 1, 2'b01, 2'b00, 1, 5'd8,  32'h0000_1002, 32'h80FF_7F01, 32'h0, 32'h0, 1, 0, 1, 32'h0000_007F);
        vecs[5]  = mk(1, 1, 2'b01, 2'b01, 0, 5'd9,  32'h0000_1002, 32'h1234_8001, 32'h0, 32'h0, 1, 0, 1, 32'hFFFF_8001);
        vecs[6]  = mk(1, 1, 2'b01, 2'b01, 1, 5'd9,  32'h0000_1000, 32'h1234_8001, 32'h0, 32'h0, 1, 0, 1, 32'h0000_1234);
        vecs[7]  = mk(1, 1, 2'b01, 2'b01, 0, 5'd9,  32'h0000_1001, 32'h1234_8001, 32'h0, 32'h0, 0, 1, 0, 32'h0);
        vecs[8]  = mk(1, 1, 2'b01, 2'b10, 0, 5'd10, 32'h0000_2000, 32'hDEAD_BEEF, 32'h0, 32'h0, 1, 0, 1, 32'hDEAD_BEEF);
        vecs[9]  = mk(1, 1, 2'b01, 2'b10, 0, 5'd10, 32'h0000_2002, 32'hDEAD_BEEF, 32'h0, 32'h0, 0, 1, 0, 32'h0);
        vecs[10] = mk(1, 1, 2'b01, 2'b11, 0, 5'd10, 32'h0000_2000, 32'hDEAD_BEEF, 32'h0, 32'h0, 0, 1, 0, 32'h0);
        vecs[11] = mk(1, 1, 2'b00, 2'b10, 0, 5'd0,  32'h0000_0077, 32'h0,         32'h0, 32'h0, 0, 0, 1, 32'h0000_0077);
        vecs[12] = mk(1, 1, 2'b10, 2'b10, 0, 5'd31, 32'h0000_0001, 32'h0, 32'h0040_0008, 32'h0, 1, 0, 1, 32'h0040_0008);
        vecs[13] = mk(1, 1, 2'b11, 2'b10, 0, 5'd3,  32'h0000_0001, 32'h0, 32'h0, 32'h1234_0000, 1, 0, 1, 32'h1234_0000);
        vecs[14] = mk(1, 0, 2'b00, 2'b10, 0, 5'd4,  32'h0000_0099, 32'h0,         32'h0, 32'h0, 0, 0, 1, 32'h0000_0099);
        vecs[15] = mk(0, 1, 2'b00, 2'b10, 0, 5'd4,  32'h0000_0099, 32'h0,         32'h0, 32'h0, 0, 0, 1, 32'h0000_0099);
        vecs[16] = mk(1, 1, 2'b00, 2'b01, 0, 5'd2,  32'h0000_1001, 32'h0,         32'h0, 32'h0, 1, 0, 1, 32'h0000_1001);
        vecs[17] = mk(0, 1, 2'b01, 2'b01, 0, 5'd2,  32'h0000_1001, 32'h1234_8001, 32'h0, 32'h0, 0, 0, 0, 32'h0);
        vecs[18] = mk(1, 1, 2'b01, 2'b01, 1, 5'd12, 32'h0000_1002, 32'h1234_8001, 32'h0, 32'h0, 1, 0, 1, 32'h0000_8001);

        rst_n = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
        drive(mk(0, 0, 2'b00, 2'b00, 0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 32'h0));
        #1;
        check("reset_we", {31'b0, rf_we_o}, 32'h0);
        check("reset_valid", {31'b0, wb_valid_o}, 32'h0);
        check("reset_wdata", rf_wdata_o, 32'h0);
        check("reset_instret", instret_o, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 19; i++) begin
            drive(vecs[i]);
            if (mvalid) exp_instret++;
            mvalid = vecs[i].valid;
            step();
            check($sformatf("v%0d_we", i), {31'b0, rf_we_o}, {31'b0, vecs[i].e_we});
            check($sformatf("v%0d_waddr", i), {27'b0, rf_waddr_o}, {27'b0, vecs[i].rd});
            check($sformatf("v%0d_valid", i), {31'b0, wb_valid_o}, {31'b0, vecs[i].valid});
            check($sformatf("v%0d_mis", i), {31'b0, misalign_o}, {31'b0, vecs[i].e_mis});
            if (vecs[i].chk) check($sformatf("v%0d_wdata", i), rf_wdata_o, vecs[i].e_wdata);
            check($sformatf("v%0d_instret", i), instret_o, exp_instret);
        end

        // Stall for three cycles, then release exactly once.
        drive(mk(1, 1, 2'b00, 2'b10, 0, 5'd7, 32'h55, 32'h0, 32'h0, 32'h0, 1, 0, 1, 32'h55));
        if (mvalid) exp_instret++;
        mvalid = 1'b1;
        step();
        check("stall_pre_wdata", rf_wdata_o, 32'h55);
        stall_i = 1'b1;
        drive(mk(1, 1, 2'b00, 2'b10, 0, 5'd9, 32'hAA, 32'h0, 32'h0, 32'h0, 1, 0, 1, 32'hAA));
        for (int c = 0; c < 3; c++) begin
            step();
            check($sformatf("stall%0d_wdata", c), rf_wdata_o, 32'h55);
            check($sformatf("stall%0d_waddr", c), {27'b0, rf_waddr_o}, 32'd7);
            check($sformatf("stall%0d_we", c), {31'b0, rf_we_o}, 32'h1);
            check($sformatf("stall%0d_instret", c), instret_o, exp_instret);
        end
        stall_i = 1'b0;
        drive(mk(0, 0, 2'b00, 2'b10, 0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 32'h0));
        exp_instret++;
        mvalid = 1'b0;
        step();
        check("release_instret", instret_o, exp_instret);
        check("release_valid", {31'b0, wb_valid_o}, 32'h0);
        step();
        check("release_once", instret_o, exp_instret);

        // Flush wins over stall and does not retire the flushed instruction.
        drive(mk(1, 1, 2'b00, 2'b10, 0, 5'd6, 32'h66, 32'h0, 32'h0, 32'h0, 1, 0, 1, 32'h66));
        mvalid = 1'b1;
        step();
        check("flush_pre_valid", {31'b0, wb_valid_o}, 32'h1);
        stall_i = 1'b1; flush_i = 1'b1;
        mvalid = 1'b0;
        step();
        check("flush_valid", {31'b0, wb_valid_o}, 32'h0);
        check("flush_we", {31'b0, rf_we_o}, 32'h0);
        check("flush_instret", instret_o, exp_instret);
        stall_i = 1'b0; flush_i = 1'b0;

        // Asynchronous reset between clock edges.
        drive(mk(1, 1, 2'b00, 2'b10, 0, 5'd10, 32'h10, 32'h0, 32'h0, 32'h0, 1, 0, 1, 32'h10));
        mvalid = 1'b1;
        step();
        exp_instret++;
        step();
        check("areset_pre_we", {31'b0, rf_we_o}, 32'h1);
        check("areset_pre_instret", instret_o, exp_instret);
        #2 rst_n = 1'b0;
        #1;
        check("areset_we", {31'b0, rf_we_o}, 32'h0);
        check("areset_valid", {31'b0, wb_valid_o}, 32'h0);
        check("areset_instret", instret_o, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
